imem_loader: RTL and testbench

- Host-side program loader: the write end of the instruction memory port that the pipeline's fetch stage reads.
- Accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words.
- Writes the words into instruction memory from address 0 upward, checks an XOR checksum, then releases the CPU core from hold.
- Sits beside the core at top level. It owns the instruction-memory write port and the core's hold/reset-release signal.

---
 rtl/imem_loader_if.sv | 39 +++
 rtl/imem_loader.sv | 159 +++++++++++++++
 tb/tb_imem_loader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader_if
// Brief    : Host byte stream (valid/ready) plus instruction-memory write port
//            used by the program loader.
// Revision : 1.0  initial release
// ============================================================================
interface imem_loader_if #(
    parameter int AW = 8,
    parameter int IW = 16
);
    logic          in_valid;
    logic [7:0]    in_data;
    logic          in_ready;
    logic          im_wen;
    logic [AW-1:0] im_addr;
    logic [IW-1:0] im_wdata;

    // Host side: drives bytes, observes the memory write port
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  im_wen,
        input  im_addr,
        input  im_wdata
    );

    // Loader side: consumes bytes, owns the memory write port
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output im_wen,
        output im_addr,
        output im_wdata
    );
endinterface
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_loader
// Brief    : Receives a length-prefixed, XOR-checksummed byte frame, writes
//            16-bit words into instruction memory from address 0 upward and
//            releases the core from hold on a good checksum.
// Revision : 1.0  initial release
// ============================================================================
module imem_loader #(
    parameter int AW = 8,
    parameter int IW = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    input  wire logic     start,
    imem_loader_if.slave  bus,
    output logic          cpu_hold,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam logic [3:0] c_ST_IDLE    = 4'd0;
    localparam logic [3:0] c_ST_LEN_HI  = 4'd1;
    localparam logic [3:0] c_ST_LEN_LO  = 4'd2;
    localparam logic [3:0] c_ST_DATA_HI = 4'd3;
    localparam logic [3:0] c_ST_DATA_LO = 4'd4;
    localparam logic [3:0] c_ST_WRITE   = 4'd5;
    localparam logic [3:0] c_ST_CHK     = 4'd6;
    localparam logic [3:0] c_ST_DONE    = 4'd7;
    localparam logic [3:0] c_ST_ERR     = 4'd8;

    // Largest word count that fits the memory; compared 17 bits wide so that
    // a 16-bit length of 2^AW is representable.
    localparam logic [16:0] c_DEPTH   = 17'(2 ** AW);
    localparam logic [AW-1:0] c_ADDR_ONE = AW'(1);

    logic [3:0]    r_state;
    logic [3:0]    w_next;
    logic [15:0]   r_len;
    logic [15:0]   r_cnt;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_hi;
    logic [7:0]    r_chk;
    logic [IW-1:0] r_wdata;

    logic          w_accept;
    logic          w_start_ok;
    logic [15:0]   w_len_full;
    logic          w_len_over;

    assign w_accept   = bus.in_valid & bus.in_ready;
    // start only takes effect when no session is running
    assign w_start_ok = start & ((r_state == c_ST_IDLE) | (r_state == c_ST_DONE) |
                                 (r_state == c_ST_ERR));
    assign w_len_full = {r_len[15:8], bus.in_data};
    assign w_len_over = {1'b0, w_len_full} > c_DEPTH;

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE, c_ST_DONE, c_ST_ERR: begin
                if (start) w_next = c_ST_LEN_HI;
            end
            c_ST_LEN_HI: begin
                if (w_accept) w_next = c_ST_LEN_LO;
            end
            c_ST_LEN_LO: begin
                if (w_accept) begin
                    if (w_len_over)             w_next = c_ST_ERR;
                    else if (w_len_full == '0)  w_next = c_ST_CHK;
                    else                        w_next = c_ST_DATA_HI;
                end
            end
            c_ST_DATA_HI: begin
                if (w_accept) w_next = c_ST_DATA_LO;
            end
            c_ST_DATA_LO: begin
                if (w_accept) w_next = c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if ((r_cnt + 16'd1) == r_len) w_next = c_ST_CHK;
                else                          w_next = c_ST_DATA_HI;
            end
            c_ST_CHK: begin
                if (w_accept) begin
                    if (bus.in_data == r_chk) w_next = c_ST_DONE;
                    else                      w_next = c_ST_ERR;
                end
            end
            default: w_next = c_ST_IDLE;
        endcase
    end

    // Length, word counter, address, checksum and word assembly
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_len   <= '0;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_hi    <= '0;
            r_chk   <= '0;
            r_wdata <= '0;
        end else if (w_start_ok) begin
            r_len  <= '0;
            r_cnt  <= '0;
            r_addr <= '0;
            r_chk  <= '0;
        end else begin
            case (r_state)
                c_ST_LEN_HI: if (w_accept) begin
                    r_len[15:8] <= bus.in_data;
                    r_chk       <= r_chk ^ bus.in_data;
                end
                c_ST_LEN_LO: if (w_accept) begin
                    r_len[7:0] <= bus.in_data;
                    r_chk      <= r_chk ^ bus.in_data;
                end
                c_ST_DATA_HI: if (w_accept) begin
                    r_hi  <= bus.in_data;
                    r_chk <= r_chk ^ bus.in_data;
                end
                c_ST_DATA_LO: if (w_accept) begin
                    r_wdata <= IW'({r_hi, bus.in_data});
                    r_chk   <= r_chk ^ bus.in_data;
                end
                c_ST_WRITE: begin
                    r_addr <= r_addr + c_ADDR_ONE;
                    r_cnt  <= r_cnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure decodes of the registered state
    assign bus.in_ready = (r_state == c_ST_LEN_HI)  | (r_state == c_ST_LEN_LO) |
                          (r_state == c_ST_DATA_HI) | (r_state == c_ST_DATA_LO) |
                          (r_state == c_ST_CHK);
    assign bus.im_wen   = (r_state == c_ST_WRITE);
    assign bus.im_addr  = r_addr;
    assign bus.im_wdata = r_wdata;
    assign busy         = bus.in_ready | (r_state == c_ST_WRITE);
    assign cpu_hold     = (r_state != c_ST_DONE);
    assign done         = (r_state == c_ST_DONE);
    assign err          = (r_state == c_ST_ERR);

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Directed bench for imem_loader: good/bad frames, length limits,
//            zero length, stalls with stray start pulses, reset mid-load.
// Revision : 1.0  initial release
// ============================================================================
module tb_imem_loader;

    logic clk;
    logic rst;
    logic start;
    logic cpu_hold;
    logic busy;
    logic done;
    logic err;

    int total = 0;
    int bad   = 0;
    int wcount = 0;

    imem_loader_if #(.AW(8), .IW(16)) bus ();

    imem_loader #(.AW(8), .IW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bus      (bus),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count memory writes, sampled mid-cycle
    always @(negedge clk) begin
        if (bus.im_wen === 1'b1) wcount++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present one byte after 'gap' idle cycles (optionally pulsing start
    // during the gap); returns #1 after the accepting edge.
    task automatic send(input logic [7:0] b, input int gap, input bit pulse);
        int n;
        @(negedge clk);
        for (int g = 0; g < gap; g++) begin
            start = (pulse && g == 0);
            @(negedge clk);
        end
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("send_timeout", 32'(n), 32'd0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [7:0] hi, input logic [7:0] lo,
                             input logic [7:0] addr, input int gap, input bit pulse);
        send(hi, gap, pulse);
        send(lo, gap, pulse);
        check("wr_wen",  32'(bus.im_wen),   32'd1);
        check("wr_addr", 32'(bus.im_addr),  32'(addr));
        check("wr_data", 32'(bus.im_wdata), 32'({hi, lo}));
    endtask

    task automatic begin_session();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wcount = 0;
        check("sess_busy", 32'(busy),         32'd1);
        check("sess_hold", 32'(cpu_hold),     32'd1);
        check("sess_rdy",  32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold",  32'(cpu_hold),     32'd1);
        check("rst_rdy",   32'(bus.in_ready), 32'd0);
        check("rst_wen",   32'(bus.im_wen),   32'd0);
        check("rst_addr",  32'(bus.im_addr),  32'd0);
        check("rst_wdata", 32'(bus.im_wdata), 32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_done",  32'(done),         32'd0);
        check("rst_err",   32'(err),          32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_hold", 32'(cpu_hold),     32'd1);
        check("idle_rdy",  32'(bus.in_ready), 32'd0);
        check("idle_wr",   32'(wcount),       32'd0);
        check("idle_done", 32'(done | err),   32'd0);

        // Good 2-word frame, checksum 7F
        begin_session();
        send(8'h00, 0, 1'b0);
        send(8'h02, 0, 1'b0);
        send_word(8'hA1, 8'h23, 8'd0, 0, 1'b0);
        send_word(8'hF0, 8'h0F, 8'd1, 0, 1'b0);
        send(8'h7F, 0, 1'b0);
        check("good_done", 32'(done),         32'd1);
        check("good_err",  32'(err),          32'd0);
        check("good_hold", 32'(cpu_hold),     32'd0);
        check("good_busy", 32'(busy),         32'd0);
        check("good_rdy",  32'(bus.in_ready), 32'd0);
        check("good_wr",   32'(wcount),       32'd2);

        // Same frame, bad checksum 7E
        begin_session();
        check("bad_done_clr", 32'(done), 32'd0);
        send(8'h00, 0, 1'b0);
        send(8'h02, 0, 1'b0);
        send_word(8'hA1, 8'h23, 8'd0, 0, 1'b0);
        send_word(8'hF0, 8'h0F, 8'd1, 0, 1'b0);
        send(8'h7E, 0, 1'b0);
        check("bad_err",  32'(err),      32'd1);
        check("bad_done", 32'(done),     32'd0);
        check("bad_hold", 32'(cpu_hold), 32'd1);
        check("bad_wr",   32'(wcount),   32'd2);

        // Length 257 overflows a 256-word memory; stray valid is ignored
        begin_session();
        send(8'h01, 0, 1'b0);
        send(8'h01, 0, 1'b0);
        check("ovf_err", 32'(err),          32'd1);
        check("ovf_rdy", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h55;
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b0;
        check("ovf_stay", 32'(err),    32'd1);
        check("ovf_wr",   32'(wcount), 32'd0);

        // Zero-length frame
        begin_session();
        send(8'h00, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        check("zero_chk_rdy", 32'(bus.in_ready), 32'd1);
        send(8'h00, 0, 1'b0);
        check("zero_done", 32'(done),     32'd1);
        check("zero_hold", 32'(cpu_hold), 32'd0);
        check("zero_wr",   32'(wcount),   32'd0);

        // Stalled 2-word frame with start pulses mid-load
        begin_session();
        send(8'h00, 3, 1'b1);
        send(8'h02, 0, 1'b0);
        send(8'hA1, 5, 1'b1);
        send(8'h23, 1, 1'b0);
        check("gap_wen0",  32'(bus.im_wen),   32'd1);
        check("gap_addr0", 32'(bus.im_addr),  32'd0);
        check("gap_data0", 32'(bus.im_wdata), 32'h0000A123);
        send_word(8'hF0, 8'h0F, 8'd1, 2, 1'b1);
        send(8'h7F, 4, 1'b1);
        check("gap_done", 32'(done),   32'd1);
        check("gap_err",  32'(err),    32'd0);
        check("gap_wr",   32'(wcount), 32'd2);

        // Length 256 is legal; then reset after first HI byte
        begin_session();
        send(8'h01, 0, 1'b0);
        send(8'h00, 0, 1'b0);
        check("max_err", 32'(err),          32'd0);
        check("max_rdy", 32'(bus.in_ready), 32'd1);
        send(8'hA1, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("mrst_busy", 32'(busy),         32'd0);
        check("mrst_hold", 32'(cpu_hold),     32'd1);
        check("mrst_rdy",  32'(bus.in_ready), 32'd0);
        check("mrst_err",  32'(err),          32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h23;
        repeat (5) @(negedge clk);
        bus.in_valid = 1'b0;
        check("mrst_wr",   32'(wcount),       32'd0);
        check("mrst_addr", 32'(bus.im_addr),  32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
